// File: rtl/sdram_avalon_controller.sv
// Single-port SDR SDRAM controller (4M x 16) behind a waitrequest slave port.
// Closed-page policy: every access is ACTIVE then READ/WRITE with auto-precharge.
module sdram_avalon_controller #(
    parameter int INIT_WAIT      = 5000,
    parameter int REFRESH_CYCLES = 780,
    parameter int TRP            = 1,
    parameter int TRCD           = 2,
    parameter int TRFC           = 4,
    parameter int TMRD           = 2,
    parameter int TWR            = 2,
    parameter int CAS_LATENCY    = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [21:0] az_addr,
    input  logic [1:0]  az_be_n,
    input  logic        az_cs,
    input  logic [15:0] az_data,
    input  logic        az_rd_n,
    input  logic        az_wr_n,
    output logic [15:0] za_data,
    output logic        za_valid,
    output logic        za_waitrequest,
    output logic        init_done,
    output logic [11:0] zs_addr,
    output logic [1:0]  zs_ba,
    output logic        zs_cs_n,
    output logic        zs_ras_n,
    output logic        zs_cas_n,
    output logic        zs_we_n,
    output logic        zs_cke,
    output logic [1:0]  zs_dqm,
    inout  wire  [15:0] zs_dq
);

    localparam logic [3:0] S_INIT_WAIT    = 4'd0;
    localparam logic [3:0] S_INIT_PRE     = 4'd1;
    localparam logic [3:0] S_INIT_REF1    = 4'd2;
    localparam logic [3:0] S_INIT_REF2    = 4'd3;
    localparam logic [3:0] S_INIT_LMR     = 4'd4;
    localparam logic [3:0] S_IDLE         = 4'd5;
    localparam logic [3:0] S_ACT          = 4'd6;
    localparam logic [3:0] S_RW_WAIT      = 4'd7;
    localparam logic [3:0] S_READ         = 4'd8;
    localparam logic [3:0] S_READ_WAIT    = 4'd9;
    localparam logic [3:0] S_WRITE        = 4'd10;
    localparam logic [3:0] S_WRITE_RECOV  = 4'd11;
    localparam logic [3:0] S_REFRESH      = 4'd12;
    localparam logic [3:0] S_REFRESH_WAIT = 4'd13;

    localparam logic [3:0] CMD_INH = 4'b1111;
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;

    logic [3:0]  state, state_d;
    logic [15:0] cnt, cnt_d;
    logic [15:0] ref_cnt, ref_cnt_d;
    logic        ref_pend, ref_pend_d, ref_tick, ref_clr;
    logic [21:0] lat_addr, lat_addr_d;
    logic [15:0] lat_data, lat_data_d;
    logic [1:0]  lat_be_n, lat_be_n_d;
    logic        lat_wr, lat_wr_d;
    logic [3:0]  cmd, cmd_d;
    logic [11:0] addr_d;
    logic [1:0]  ba_d, dqm_d;
    logic        dq_oe, dq_oe_d;
    logic [15:0] dq_out, dq_out_d;
    logic [15:0] za_data_d;
    logic        za_valid_d, wait_d, init_done_d;
    logic        req;

    assign {zs_cs_n, zs_ras_n, zs_cas_n, zs_we_n} = cmd;
    assign zs_dq    = dq_oe ? dq_out : 16'hzzzz;
    assign req      = az_cs && (!az_rd_n || !az_wr_n);
    assign ref_tick = init_done &&
                      (ref_cnt == 16'(REFRESH_CYCLES - 1));

    // cnt holds the number of NOP cycles still owed after the command on the pins
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        cmd_d       = CMD_NOP;
        addr_d      = zs_addr;
        ba_d        = zs_ba;
        dqm_d       = 2'b11;
        dq_oe_d     = 1'b0;
        dq_out_d    = dq_out;
        za_data_d   = za_data;
        za_valid_d  = 1'b0;
        init_done_d = init_done;
        lat_addr_d  = lat_addr;
        lat_data_d  = lat_data;
        lat_be_n_d  = lat_be_n;
        lat_wr_d    = lat_wr;
        ref_clr     = 1'b0;
        unique case (state)
            S_INIT_WAIT: begin
                if (cnt == 16'd0) begin
                    cmd_d   = CMD_PRE;
                    addr_d  = 12'h400;
                    ba_d    = 2'b00;
                    state_d = S_INIT_PRE;
                    cnt_d   = 16'(TRP);
                end else begin
                    cnt_d = cnt - 16'd1;
                end
            end
            S_INIT_PRE, S_INIT_REF1: begin
                if (cnt == 16'd0) begin
                    cmd_d   = CMD_REF;
                    state_d = (state == S_INIT_PRE) ? S_INIT_REF1
                                                    : S_INIT_REF2;
                    cnt_d   = 16'(TRFC);
                end else begin
                    cnt_d = cnt - 16'd1;
                end
            end
            S_INIT_REF2: begin
                if (cnt == 16'd0) begin
                    cmd_d   = CMD_LMR;
                    addr_d  = 12'(CAS_LATENCY << 4);
                    ba_d    = 2'b00;
                    state_d = S_INIT_LMR;
                    cnt_d   = 16'(TMRD);
                end else begin
                    cnt_d = cnt - 16'd1;
                end
            end
            S_INIT_LMR: begin
                if (cnt == 16'd0) begin
                    init_done_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt - 16'd1;
                end
            end
            S_IDLE: begin
                if (ref_pend) begin
                    cmd_d   = CMD_REF;
                    state_d = S_REFRESH;
                    cnt_d   = 16'(TRFC);
                end else if (req && !za_waitrequest) begin
                    lat_addr_d = az_addr;
                    lat_data_d = az_data;
                    lat_be_n_d = az_be_n;
                    lat_wr_d   = !az_wr_n;
                    cmd_d      = CMD_ACT;
                    ba_d       = az_addr[9:8];
                    addr_d     = az_addr[21:10];
                    state_d    = S_ACT;
                    cnt_d      = 16'(TRCD - 1);
                end
            end
            S_ACT, S_RW_WAIT: begin
                if (cnt == 16'd0) begin
                    ba_d   = lat_addr[9:8];
                    addr_d = {4'b0100, lat_addr[7:0]};
                    if (lat_wr) begin
                        cmd_d    = CMD_WR;
                        dq_oe_d  = 1'b1;
                        dq_out_d = lat_data;
                        dqm_d    = lat_be_n;
                        state_d  = S_WRITE;
                        cnt_d    = 16'(TWR + TRP);
                    end else begin
                        cmd_d   = CMD_RD;
                        dqm_d   = 2'b00;
                        state_d = S_READ;
                        cnt_d   = 16'(CAS_LATENCY);
                    end
                end else begin
                    cnt_d   = cnt - 16'd1;
                    state_d = S_RW_WAIT;
                end
            end
            S_READ, S_READ_WAIT: begin
                if (cnt == 16'd0) begin
                    za_data_d  = zs_dq;
                    za_valid_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    dqm_d   = 2'b00;
                    cnt_d   = cnt - 16'd1;
                    state_d = S_READ_WAIT;
                end
            end
            S_WRITE, S_WRITE_RECOV: begin
                if (cnt == 16'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt - 16'd1;
                    state_d = S_WRITE_RECOV;
                end
            end
            S_REFRESH, S_REFRESH_WAIT: begin
                if (cnt == 16'd0) begin
                    ref_clr = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt - 16'd1;
                    state_d = S_REFRESH_WAIT;
                end
            end
            default: begin
                state_d = S_INIT_WAIT;
                cnt_d   = 16'(INIT_WAIT);
            end
        endcase
        ref_cnt_d  = (!init_done || ref_tick) ? 16'd0 : ref_cnt + 16'd1;
        ref_pend_d = ref_tick || (ref_pend && !ref_clr);
        wait_d     = !((state_d == S_IDLE) && !ref_pend_d);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= S_INIT_WAIT;
            cnt            <= 16'(INIT_WAIT);
            ref_cnt        <= 16'd0;
            ref_pend       <= 1'b0;
            lat_addr       <= 22'd0;
            lat_data       <= 16'd0;
            lat_be_n       <= 2'b11;
            lat_wr         <= 1'b0;
            cmd            <= CMD_INH;
            zs_addr        <= 12'd0;
            zs_ba          <= 2'b00;
            zs_dqm         <= 2'b11;
            zs_cke         <= 1'b1;
            dq_oe          <= 1'b0;
            dq_out         <= 16'd0;
            za_data        <= 16'd0;
            za_valid       <= 1'b0;
            za_waitrequest <= 1'b1;
            init_done      <= 1'b0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            ref_cnt        <= ref_cnt_d;
            ref_pend       <= ref_pend_d;
            lat_addr       <= lat_addr_d;
            lat_data       <= lat_data_d;
            lat_be_n       <= lat_be_n_d;
            lat_wr         <= lat_wr_d;
            cmd            <= cmd_d;
            zs_addr        <= addr_d;
            zs_ba          <= ba_d;
            zs_dqm         <= dqm_d;
            zs_cke         <= 1'b1;
            dq_oe          <= dq_oe_d;
            dq_out         <= dq_out_d;
            za_data        <= za_data_d;
            za_valid       <= za_valid_d;
            za_waitrequest <= wait_d;
            init_done      <= init_done_d;
        end
    end

endmodule

// File: tb/tb_sdram_avalon_controller.sv
// Bench for sdram_avalon_controller: SDRAM device model plus a read-data
// scoreboard fed from a reference memory of everything the bench wrote.
module tb_sdram_avalon_controller;

    localparam int CL = 3;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_LMR = 4'b0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [21:0] az_addr = '0;
    logic [1:0]  az_be_n = 2'b11;
    logic        az_cs = 1'b0;
    logic [15:0] az_data = '0;
    logic        az_rd_n = 1'b1;
    logic        az_wr_n = 1'b1;
    logic [15:0] za_data;
    logic        za_valid, za_waitrequest, init_done;
    logic [11:0] zs_addr;
    logic [1:0]  zs_ba, zs_dqm;
    logic        zs_cs_n, zs_ras_n, zs_cas_n, zs_we_n, zs_cke;
    wire  [15:0] zs_dq;
    wire  [3:0]  cmd = {zs_cs_n, zs_ras_n, zs_cas_n, zs_we_n};

    int checks = 0;
    int errors = 0;
    logic [15:0] ref_mem [int];
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    sdram_avalon_controller #(
        .INIT_WAIT(10),
        .REFRESH_CYCLES(50)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .az_addr(az_addr), .az_be_n(az_be_n), .az_cs(az_cs),
        .az_data(az_data), .az_rd_n(az_rd_n), .az_wr_n(az_wr_n),
        .za_data(za_data), .za_valid(za_valid),
        .za_waitrequest(za_waitrequest), .init_done(init_done),
        .zs_addr(zs_addr), .zs_ba(zs_ba),
        .zs_cs_n(zs_cs_n), .zs_ras_n(zs_ras_n),
        .zs_cas_n(zs_cas_n), .zs_we_n(zs_we_n),
        .zs_cke(zs_cke), .zs_dqm(zs_dqm), .zs_dq(zs_dq)
    );

    // SDRAM device: storage indexed by {bank, col}; read data driven CL cycles after READ
    logic [15:0]   mdl_mem [1024];
    logic [CL-1:0] rd_sr = '0;
    logic [15:0]   rd_val = '0;

    always @(posedge clk) begin
        rd_sr <= {rd_sr[CL-2:0], cmd == C_RD};
        if (cmd == C_RD)
            rd_val <= mdl_mem[{zs_ba, zs_addr[7:0]}];
        if (cmd == C_WR) begin
            if (!zs_dqm[0]) mdl_mem[{zs_ba, zs_addr[7:0]}][7:0]  <= zs_dq[7:0];
            if (!zs_dqm[1]) mdl_mem[{zs_ba, zs_addr[7:0]}][15:8] <= zs_dq[15:8];
        end
    end

    assign zs_dq = rd_sr[CL-1] ? rd_val : 16'hzzzz;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_init_sequence();
        logic [3:0] seq [$];
        repeat (10) seq.push_back(C_NOP);
        seq.push_back(C_PRE);
        seq.push_back(C_NOP);
        seq.push_back(C_REF);
        repeat (4) seq.push_back(C_NOP);
        seq.push_back(C_REF);
        repeat (4) seq.push_back(C_NOP);
        seq.push_back(C_LMR);
        repeat (2) seq.push_back(C_NOP);
        for (int i = 0; i < seq.size(); i++) begin
            step();
            checks++;
            if (cmd !== seq[i] || init_done !== 1'b0 || za_valid !== 1'b0) begin
                errors++;
                $display("FAIL init_seq[%0d] got cmd=%b init_done=%b za_valid=%b want cmd=%b init_done=0 za_valid=0",
                         i, cmd, init_done, za_valid, seq[i]);
            end
            if (seq[i] == C_PRE) begin
                checks++;
                if (zs_addr[10] !== 1'b1) begin
                    errors++;
                    $display("FAIL init_pre_a10 got %b want 1", zs_addr[10]);
                end
            end
            if (seq[i] == C_LMR) begin
                checks++;
                if (zs_addr !== 12'h030 || zs_ba !== 2'b00) begin
                    errors++;
                    $display("FAIL init_lmr got addr=%h ba=%b want addr=030 ba=00", zs_addr, zs_ba);
                end
            end
        end
        step();
        checks++;
        if (init_done !== 1'b1 || za_waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL init_done got init_done=%b waitreq=%b want 1 0", init_done, za_waitrequest);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        checks++;
        if ({cmd, zs_cke, zs_addr, zs_ba, zs_dqm, za_valid, za_data, za_waitrequest, init_done}
            !== {4'b1111, 1'b1, 12'h000, 2'b00, 2'b11, 1'b0, 16'h0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_vals got cmd=%b cke=%b addr=%h ba=%b dqm=%b valid=%b data=%h wr=%b done=%b",
                     cmd, zs_cke, zs_addr, zs_ba, zs_dqm, za_valid, za_data, za_waitrequest, init_done);
        end
        reset_n = 1'b1;
        test_init_sequence();
    endtask

    // Park just after a refresh so the next access cannot collide with one
    task automatic sync_refresh();
        int n = 0;
        while (cmd !== C_REF && n < 200) begin step(); n++; end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL refresh_timeout got no REFRESH in %0d cycles want one", n);
        end
        n = 0;
        while (za_waitrequest !== 1'b0 && n < 50) begin step(); n++; end
    endtask

    task automatic do_access(input bit wr, input bit rd_too, input logic [21:0] a,
                             input logic [15:0] d, input logic [1:0] be);
        logic [15:0] v;
        int n = 0;
        az_addr = a; az_data = d; az_be_n = be; az_cs = 1'b1;
        az_wr_n = !wr; az_rd_n = !(!wr || rd_too);
        while (za_waitrequest !== 1'b0 && n < 200) begin step(); n++; end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL accept_timeout addr=%h got waitreq=%b want 0", a, za_waitrequest);
            az_cs = 1'b0; az_rd_n = 1'b1; az_wr_n = 1'b1;
            return;
        end
        if (wr) begin
            v = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
            if (!be[0]) v[7:0]  = d[7:0];
            if (!be[1]) v[15:8] = d[15:8];
            ref_mem[int'(a)] = v;
        end else begin
            exp_q.push_back(ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000);
        end
        step();
        az_cs = 1'b0; az_rd_n = 1'b1; az_wr_n = 1'b1;
        checks++;
        if (cmd !== C_ACT || zs_ba !== a[9:8] || zs_addr !== a[21:10]) begin
            errors++;
            $display("FAIL active addr=%h got cmd=%b ba=%b row=%h want cmd=%b ba=%b row=%h",
                     a, cmd, zs_ba, zs_addr, C_ACT, a[9:8], a[21:10]);
        end
        step();
        checks++;
        if (cmd !== C_NOP) begin
            errors++;
            $display("FAIL trcd_nop got cmd=%b want %b", cmd, C_NOP);
        end
        step();
        checks++;
        if (cmd !== (wr ? C_WR : C_RD) || zs_ba !== a[9:8] || zs_addr !== {4'b0100, a[7:0]}) begin
            errors++;
            $display("FAIL rw_cmd addr=%h got cmd=%b ba=%b addr=%h want cmd=%b ba=%b addr=%h",
                     a, cmd, zs_ba, zs_addr, wr ? C_WR : C_RD, a[9:8], {4'b0100, a[7:0]});
        end
        checks++;
        if (wr ? (zs_dq !== d || zs_dqm !== be) : (zs_dqm !== 2'b00)) begin
            errors++;
            $display("FAIL rw_data got dq=%h dqm=%b want dq=%h dqm=%b",
                     zs_dq, zs_dqm, d, wr ? be : 2'b00);
        end
        for (int c = 4; c <= 6; c++) begin
            step();
            checks++;
            if (wr ? (cmd !== C_NOP || za_waitrequest !== 1'b1 || zs_dqm !== 2'b11)
                   : (cmd !== C_NOP || zs_dqm !== 2'b00 || za_valid !== 1'b0)) begin
                errors++;
                $display("FAIL cycle%0d got cmd=%b waitreq=%b dqm=%b valid=%b", c, cmd,
                         za_waitrequest, zs_dqm, za_valid);
            end
        end
        step();
        checks++;
        if (wr) begin
            if (za_waitrequest !== 1'b0) begin
                errors++;
                $display("FAIL write_done got waitreq=%b want 0", za_waitrequest);
            end
        end else begin
            v = exp_q.pop_front();
            if (za_valid !== 1'b1 || za_data !== v) begin
                errors++;
                $display("FAIL read_data addr=%h got valid=%b data=%h want valid=1 data=%h",
                         a, za_valid, za_data, v);
            end
            step();
            checks++;
            if (za_valid !== 1'b0) begin
                errors++;
                $display("FAIL valid_pulse got za_valid=%b want 0", za_valid);
            end
        end
    endtask

    task automatic test_write();
        sync_refresh();
        do_access(1'b1, 1'b0, 22'h000123, 16'hBEEF, 2'b00);
    endtask

    task automatic test_read();
        sync_refresh();
        do_access(1'b0, 1'b0, 22'h000123, 16'h0000, 2'b11);
    endtask

    task automatic test_byte_enable();
        sync_refresh();
        do_access(1'b1, 1'b0, 22'h000123, 16'h1234, 2'b10);
        sync_refresh();
        do_access(1'b0, 1'b0, 22'h000123, 16'h0000, 2'b11);
        checks++;
        if (ref_mem[int'(22'h000123)] !== 16'hBE34) begin
            errors++;
            $display("FAIL byte_merge got %h want BE34", ref_mem[int'(22'h000123)]);
        end
    endtask

    task automatic test_write_wins();
        sync_refresh();
        do_access(1'b1, 1'b1, 22'h3A5C7, 16'hC0DE, 2'b00);
        sync_refresh();
        do_access(1'b0, 1'b0, 22'h3A5C7, 16'h0000, 2'b11);
    endtask

    task automatic test_back_to_back();
        sync_refresh();
        do_access(1'b1, 1'b0, 22'h000200, 16'h5A5A, 2'b00);
        do_access(1'b1, 1'b0, 22'h3FF3FF, 16'hA5C3, 2'b00);
        sync_refresh();
        do_access(1'b0, 1'b0, 22'h000200, 16'h0000, 2'b11);
        do_access(1'b0, 1'b0, 22'h3FF3FF, 16'h0000, 2'b11);
    endtask

    task automatic test_refresh_priority();
        int n = 0;
        sync_refresh();
        while (za_waitrequest !== 1'b1 && n < 100) begin step(); n++; end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL pending_timeout got waitreq=%b want 1", za_waitrequest);
        end
        az_addr = 22'h000123; az_be_n = 2'b11; az_cs = 1'b1; az_rd_n = 1'b0;
        step();
        checks++;
        if (cmd !== C_REF || za_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL refresh_first got cmd=%b waitreq=%b want cmd=%b waitreq=1",
                     cmd, za_waitrequest, C_REF);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (cmd !== C_NOP || za_waitrequest !== 1'b1) begin
                errors++;
                $display("FAIL trfc_hold[%0d] got cmd=%b waitreq=%b want cmd=%b waitreq=1",
                         i, cmd, za_waitrequest, C_NOP);
            end
        end
        do_access(1'b0, 1'b0, 22'h000123, 16'h0000, 2'b11);
    endtask

    task automatic test_reset_mid_read();
        int n = 0;
        sync_refresh();
        az_addr = 22'h000200; az_be_n = 2'b11; az_cs = 1'b1; az_rd_n = 1'b0;
        while (za_waitrequest !== 1'b0 && n < 100) begin step(); n++; end
        step();
        az_cs = 1'b0; az_rd_n = 1'b1;
        step();
        step();
        step();
        reset_n = 1'b0;
        step();
        checks++;
        if ({cmd, zs_cke, zs_addr, zs_ba, zs_dqm, za_valid, za_data, za_waitrequest, init_done}
            !== {4'b1111, 1'b1, 12'h000, 2'b00, 2'b11, 1'b0, 16'h0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL abort_reset got cmd=%b cke=%b addr=%h ba=%b dqm=%b valid=%b data=%h wr=%b done=%b",
                     cmd, zs_cke, zs_addr, zs_ba, zs_dqm, za_valid, za_data, za_waitrequest, init_done);
        end
        reset_n = 1'b1;
        test_init_sequence();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_byte_enable();
        test_write_wins();
        test_back_to_back();
        test_refresh_priority();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
